// File: rtl/data_mem_lsu.sv
// Load/store initiator between the MEM stage and a byte-addressed data memory.
// Sub-doubleword stores are done as read-modify-write of the containing doubleword.
module data_mem_lsu #(
  parameter int MEM_SIZE    = 512,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic        write_q;
  logic [2:0]  f3_q;
  logic [2:0]  lane_q;
  logic [63:0] wdata_q;
  logic [63:0] rd_q;
  logic [63:0] mem_addr_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [3:0]  req_size;
  logic [2:0]  req_amask;
  logic        req_illegal;
  logic        req_misal;
  logic        req_range;
  logic        req_fault;
  logic [63:0] req_eaddr;
  logic [64:0] req_end;
  logic        req_rd_first;

  logic [5:0]  shamt;
  logic [63:0] bmask;
  logic [63:0] wmask;
  logic [63:0] merged;
  logic [63:0] field;
  logic [63:0] load_data;
  logic        accept;

  assign accept = req_valid && (state == IDLE);

  // Size, alignment and range decode of the incoming request.
  always_comb begin
    req_size  = 4'd1;
    req_amask = 3'b000;
    unique case (req_funct3[1:0])
      2'b00: begin
        req_size  = 4'd1;
        req_amask = 3'b000;
      end
      2'b01: begin
        req_size  = 4'd2;
        req_amask = 3'b001;
      end
      2'b10: begin
        req_size  = 4'd4;
        req_amask = 3'b011;
      end
      2'b11: begin
        req_size  = 4'd8;
        req_amask = 3'b111;
      end
    endcase
    req_illegal = req_write ? req_funct3[2]
                            : (req_funct3 == 3'b111);
    req_misal = (ALIGN_CHECK != 0) &&
                ((req_addr[2:0] & req_amask) != 3'b000);
    req_eaddr = (ALIGN_CHECK != 0) ? req_addr
              : {req_addr[63:3], req_addr[2:0] & ~req_amask};
    req_end   = {1'b0, req_eaddr} + {61'd0, req_size};
    req_range = req_end > 65'(MEM_SIZE);
    req_fault = req_illegal | req_misal | req_range;
    req_rd_first = !req_write || (req_funct3[1:0] != 2'b11);
  end

  // Byte-lane merge for stores and field extraction for loads.
  always_comb begin
    shamt = {lane_q, 3'b000};
    bmask = 64'hFFFF_FFFF_FFFF_FFFF;
    unique case (f3_q[1:0])
      2'b00: bmask = 64'h0000_0000_0000_00FF;
      2'b01: bmask = 64'h0000_0000_0000_FFFF;
      2'b10: bmask = 64'h0000_0000_FFFF_FFFF;
      2'b11: bmask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    wmask  = bmask << shamt;
    merged = (rd_q & ~wmask) | ((wdata_q & bmask) << shamt);
    field  = mem_read_data >> shamt;
    load_data = 64'd0;
    unique case (f3_q)
      3'b000: load_data = {{56{field[7]}}, field[7:0]};
      3'b001: load_data = {{48{field[15]}}, field[15:0]};
      3'b010: load_data = {{32{field[31]}}, field[31:0]};
      3'b011: load_data = field;
      3'b100: load_data = {56'd0, field[7:0]};
      3'b101: load_data = {48'd0, field[15:0]};
      3'b110: load_data = {32'd0, field[31:0]};
      default: load_data = 64'd0;
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            state_next = RESP;
          end else if (req_rd_first) begin
            state_next = RD;
          end else begin
            state_next = WR;
          end
        end
      end
      RD: state_next = write_q ? WR : RESP;
      WR: state_next = RESP;
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, read capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q    <= 1'b0;
      f3_q       <= 3'd0;
      lane_q     <= 3'd0;
      wdata_q    <= 64'd0;
      rd_q       <= 64'd0;
      mem_addr_q <= 64'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        lane_q  <= req_eaddr[2:0];
        wdata_q <= req_wdata;
        rdata_q <= 64'd0;
        err_q   <= req_fault;
        if (!req_fault) begin
          mem_addr_q <= {req_addr[63:3], 3'b000};
        end
      end
      if (state == RD) begin
        rd_q <= mem_read_data;
        if (!write_q) begin
          rdata_q <= load_data;
        end
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign mem_write_data = (state != WR) ? 64'd0
                        : (f3_q[1:0] == 2'b11) ? wdata_q
                        : merged;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a byte-array memory model
// (combinational read, negedge write).
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [0:511];
  logic        tb_we;
  logic [63:0] tb_a;
  logic [63:0] tb_d;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.MEM_SIZE(512), .ALIGN_CHECK(1)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always_comb begin
    mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (mem_addr[63:9] == 55'd0 && int'(mem_addr[8:0]) + i < 512)
        mem_read_data[8*i +: 8] = mem[int'(mem_addr[8:0]) + i];
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) both_cnt++;
      if (mem_write && mem_addr[63:9] == 55'd0)
        for (int i = 0; i < 8; i++)
          mem[int'(mem_addr[8:0]) + i] = mem_write_data[8*i +: 8];
      if (tb_we)
        for (int i = 0; i < 8; i++)
          mem[int'(tb_a[8:0]) + i] = tb_d[8*i +: 8];
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [63:0] wd;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [2:0] f3,
                              logic [63:0] addr, logic [63:0] wdata,
                              logic [63:0] rdata, logic err, int lat,
                              int nrd, int nwr, logic [63:0] wd);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat;
    v.nrd = nrd; v.nwr = nwr; v.wd = wd;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(logic [63:0] a, logic [63:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    @(posedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_vec(int idx, vec_t v);
    int lat, nrd, nwr;
    logic got;
    logic [63:0] wd, ma, exp_ma;
    string tag;
    lat = 0; nrd = 0; nwr = 0; got = 1'b0; wd = 64'd0; ma = 64'd0;
    exp_ma = v.err ? 64'd0 : {v.addr[63:3], 3'b000};
    tag = $sformatf("v%0d", idx);
    req_write = v.wr; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read) begin nrd++; ma = mem_addr; end
      if (mem_write) begin nwr++; wd = mem_write_data; ma = mem_addr; end
      if (resp_valid) begin got = 1'b1; lat = k; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s.timeout: no resp_valid within 8 cycles", tag);
    end
    chk({tag, ".lat"}, 64'(lat), 64'(v.lat));
    chk({tag, ".rdata"}, resp_rdata, v.rdata);
    chk({tag, ".err"}, 64'(resp_err), 64'(v.err));
    chk({tag, ".nrd"}, 64'(nrd), 64'(v.nrd));
    chk({tag, ".nwr"}, 64'(nwr), 64'(v.nwr));
    chk({tag, ".wdata"}, wd, v.wd);
    chk({tag, ".maddr"}, ma, exp_ma);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  vec_t vt [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [63:0] held, dw;
    int nwr;
    vt[0]  = mk(0, 3'd3, 64'h100, 0, 64'h0000_0008_0000_0006, 0, 2, 1, 0, 0);
    vt[1]  = mk(1, 3'd0, 64'h107, 64'hF0, 0, 0, 3, 1, 1, 64'hF000_0008_0000_0006);
    vt[2]  = mk(0, 3'd0, 64'h107, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 2, 1, 0, 0);
    vt[3]  = mk(0, 3'd4, 64'h107, 0, 64'h0000_0000_0000_00F0, 0, 2, 1, 0, 0);
    vt[4]  = mk(1, 3'd3, 64'h100, 64'h1122_3344_5566_7788, 0, 0, 2, 0, 1, 64'h1122_3344_5566_7788);
    vt[5]  = mk(1, 3'd0, 64'h102, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0, 3, 1, 1, 64'h1122_3344_55AB_7788);
    vt[6]  = mk(0, 3'd3, 64'h100, 0, 64'h1122_3344_55AB_7788, 0, 2, 1, 0, 0);
    vt[7]  = mk(0, 3'd1, 64'h106, 0, 64'h0000_0000_0000_1122, 0, 2, 1, 0, 0);
    vt[8]  = mk(1, 3'd1, 64'h104, 64'h8000, 0, 0, 3, 1, 1, 64'h1122_8000_55AB_7788);
    vt[9]  = mk(0, 3'd1, 64'h104, 0, 64'hFFFF_FFFF_FFFF_8000, 0, 2, 1, 0, 0);
    vt[10] = mk(0, 3'd5, 64'h104, 0, 64'h0000_0000_0000_8000, 0, 2, 1, 0, 0);
    vt[11] = mk(1, 3'd2, 64'h108, 64'h89AB_CDEF, 0, 0, 3, 1, 1, 64'h0000_0000_89AB_CDEF);
    vt[12] = mk(0, 3'd2, 64'h108, 0, 64'hFFFF_FFFF_89AB_CDEF, 0, 2, 1, 0, 0);
    vt[13] = mk(0, 3'd6, 64'h108, 0, 64'h0000_0000_89AB_CDEF, 0, 2, 1, 0, 0);
    vt[14] = mk(0, 3'd2, 64'h102, 0, 0, 1, 1, 0, 0, 0);
    vt[15] = mk(0, 3'd3, 64'h1FC, 0, 0, 1, 1, 0, 0, 0);
    vt[16] = mk(1, 3'd3, 64'h1F8, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 2, 0, 1, 64'hDEAD_BEEF_CAFE_F00D);
    vt[17] = mk(0, 3'd3, 64'h1F8, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 2, 1, 0, 0);
    vt[18] = mk(0, 3'd0, 64'h1FF, 0, 64'hFFFF_FFFF_FFFF_FFDE, 0, 2, 1, 0, 0);
    vt[19] = mk(0, 3'd0, 64'h200, 0, 0, 1, 1, 0, 0, 0);
    vt[20] = mk(0, 3'd7, 64'h100, 0, 0, 1, 1, 0, 0, 0);
    vt[21] = mk(1, 3'd4, 64'h100, 64'h55, 0, 1, 1, 0, 0, 0);
    vt[22] = mk(1, 3'd1, 64'h101, 64'h1234, 0, 1, 1, 0, 0, 0);
    vt[23] = mk(0, 3'd3, 64'h100, 0, 64'h1122_8000_55AB_7788, 0, 2, 1, 0, 0);

    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_write = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    tb_we = 1'b0; tb_a = 64'd0; tb_d = 64'd0;
    @(posedge clk);
    preload(64'h100, 64'h0000_0008_0000_0006);
    preload(64'h110, 64'h0102_0304_0506_0708);
    @(negedge clk);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.resp_rdata", resp_rdata, 64'd0);
    chk("rst.mem_read", 64'(mem_read), 64'd0);
    chk("rst.mem_write", 64'(mem_write), 64'd0);
    chk("rst.mem_addr", mem_addr, 64'd0);
    chk("rst.mem_wdata", mem_write_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) run_vec(i, vt[i]);

    // Back-pressure: response held while resp_ready is low.
    req_write = 1'b0; req_funct3 = 3'd3; req_addr = 64'h100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 6 && got == 0; k++) begin
      if (resp_valid) got = 1;
      else @(negedge clk);
    end
    chk("bp.resp_valid", 64'(resp_valid), 64'd1);
    held = 64'h1122_8000_55AB_7788;
    req_funct3 = 3'd5; req_addr = 64'h104; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp.hold%0d.valid", k), 64'(resp_valid), 64'd1);
      chk($sformatf("bp.hold%0d.rdata", k), resp_rdata, held);
      chk($sformatf("bp.hold%0d.req_ready", k), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp.idle.req_ready", 64'(req_ready), 64'd1);
    chk("bp.idle.resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.second.accepted", 64'(req_ready), 64'd0);
    got = 0;
    for (int k = 0; k < 6 && got == 0; k++) begin
      if (resp_valid) got = 1;
      else @(negedge clk);
    end
    chk("bp.second.valid", 64'(resp_valid), 64'd1);
    chk("bp.second.rdata", resp_rdata, 64'h0000_0000_0000_8000);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during the read phase of a halfword store.
    req_write = 1'b1; req_funct3 = 3'd1; req_addr = 64'h110;
    req_wdata = 64'h7777; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rrd.mem_read", 64'(mem_read), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nwr = 0;
    if (mem_write) nwr++;
    chk("rrd.req_ready", 64'(req_ready), 64'd1);
    chk("rrd.resp_valid", 64'(resp_valid), 64'd0);
    chk("rrd.mem_addr", mem_addr, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_write) nwr++;
    end
    chk("rrd.no_write", 64'(nwr), 64'd0);
    chk("rrd.still_idle", 64'(req_ready), 64'd1);
    dw = 64'd0;
    for (int i = 0; i < 8; i++) dw[8*i +: 8] = mem[16'h110 + i];
    chk("rrd.mem_unchanged", dw, 64'h0102_0304_0506_0708);

    chk("rd_wr_overlap", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store initiator between the pipeline MEM stage and the byte-addressed data memory. It takes one load or store request per handshake and drives the memory's combinational-read / negedge-write port. Sub-doubleword loads are sign- or zero-extended. Sub-doubleword stores are done as a read-modify-write of the containing doubleword. One result is returned per request through a valid/ready response channel.

Parameters:
- MEM_SIZE, 512, number of addressable bytes; any access touching a byte at or above MEM_SIZE is an access fault.
- ALIGN_CHECK, 1, when 1, misaligned accesses fault; when 0, addr[2:0] is forced to satisfy alignment by clearing the low bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  64  extended load data; 0 for stores and faults.
- resp_err  output  1  misaligned, out-of-range or illegal funct3.
- mem_addr  output  64  doubleword address, {req_addr[63:3],3'b000}.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_write_data  output  64  doubleword to write.
- mem_read_data  input  64  combinational memory read data.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0.
- States: IDLE, RD, WR, RESP.
- Accept: a request is accepted on a posedge with req_valid && req_ready. At acceptance, latch write, funct3, addr, wdata and compute lane = addr[2:0].
- Load funct3 codes: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is illegal.
- Store funct3 codes: 000 SB, 001 SH, 010 SW, 011 SD; all others are illegal.
- Access size: 1, 2, 4 or 8 bytes.
- Fault check at accept:
  - illegal funct3;
  - (ALIGN_CHECK and addr mod size != 0);
  - (addr + size > MEM_SIZE).
  - On fault: next state RESP with resp_err=1 and resp_rdata=0. mem_read and mem_write never assert for that request.
- Transitions:
  - IDLE -> RD for a load or a sub-doubleword store.
  - IDLE -> WR for SD.
  - RD -> RESP for a load.
  - RD -> WR for a store.
  - WR -> RESP.
  - RESP -> IDLE on resp_ready.
- RD cycle: mem_read=1 and mem_addr is valid for the whole cycle. mem_read_data is captured at the closing posedge into an internal doubleword register.
- WR cycle: mem_write=1 for exactly one full cycle, so the memory samples it at the mid-cycle negedge. mem_write_data is valid for the whole cycle.
  - For SD, mem_write_data = req_wdata.
  - Otherwise mem_write_data = captured doubleword with bytes [lane .. lane+size-1] replaced by req_wdata[8*size-1:0].
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Load result: the size-byte field at lane, shifted to bit 0. Sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU/LD. resp_rdata is 0 for stores.
- Latency from accept edge to resp_valid:
  - load: 2 cycles;
  - SD: 2 cycles;
  - SB/SH/SW: 3 cycles;
  - fault: 1 cycle.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready is seen at a posedge. resp_valid then drops the next cycle and req_ready rises. There is no request/response overlap, so throughput is one request per (latency + 1) cycles minimum.
- Reset mid-operation: reset forces IDLE and all reset values at that posedge.
  - A WR cycle already in progress completes its negedge write.
  - Reset sampled at the posedge that would enter WR prevents the write.
  - Any pending response is dropped.
- mem_addr bits [2:0] are always 0, and mem_addr holds its value outside RD/WR.

Test Plan:
- LD at 0x100 with memory bytes 0x100..0x107 = 06 00 00 00 08 00 00 00 -> mem_read high 1 cycle, resp_rdata=0x0000000800000006 at accept+2, resp_err=0.
- LB at 0x107 holding 0xF0 -> resp_rdata=0xFFFFFFFFFFFFFFF0; LBU at the same address -> 0x00000000000000F0.
- SB 0xAB to 0x102 over doubleword 0x1122334455667788 -> RD cycle, then WR with mem_write_data=0x1122334455AB7788, resp_valid at accept+3; a following LD at 0x100 returns the same value.
- LW at 0x102 with ALIGN_CHECK=1 -> resp_err=1 at accept+1, mem_read/mem_write never assert; LD at 0x1FC (MEM_SIZE=512) -> resp_err=1.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is not accepted until 1 cycle after resp_ready.
- Assert reset during the RD cycle of an SH -> next cycle IDLE, req_ready=1, mem_write never asserted, target memory unchanged.
